psum_bram_reader: RTL

Drain engine for the partial-sum BRAM. The accelerator core writes this BRAM; this block reads it back. On a start pulse it reads a configured block of words from the BRAM read port (fixed read latency) and presents them as a valid/ready stream, asserting last on the final word. This stream is the PS/DMA-facing path that replaces word-by-word readout through the BRAM controller mux.

---
 rtl/psum_bram_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/psum_bram_reader.sv
// Drains a block of partial-sum BRAM words as a valid/ready stream; first beat RD_LATENCY+1 cycles after the first read.
// Reads stall on FIFO credit while i_tready is low. Define PSUM_READER_RELU_EN to clamp negative words to zero.
module psum_bram_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_last_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [NUM_BYTE-1:0]   mem_wren,
  output logic                  mem_enb,
  output logic                  mem_rst,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    last_idx_q, last_idx_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [RD_LATENCY-1:0]   vld_sr_q, vld_sr_d;
  logic [RD_LATENCY-1:0]   last_sr_q, last_sr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   fifo_dat_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_dat_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        in_flight;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   wr_dat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(vld_sr_q[i]);
    end
  end

  // Credit counts reads still in the BRAM pipe plus words already buffered, so a push always has room.
  assign issue = (state_q == RUN) && !i_abort && ((in_flight + count_q) < CNT_W'(FIFO_DEPTH));
  assign push  = vld_sr_q[RD_LATENCY-1];
  assign pop   = (count_q != '0) && i_tready;

`ifdef PSUM_READER_RELU_EN
  assign wr_dat = mem_odat[DATA_WIDTH-1] ? '0 : mem_odat;
`else
  assign wr_dat = mem_odat;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    next_addr_d = next_addr_q;
    mem_addr_d  = mem_addr_q;
    vld_sr_d    = vld_sr_q;
    last_sr_d   = last_sr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_dat_d  = fifo_dat_q;
    fifo_last_d = fifo_last_q;
    done_d      = done_q;

    if (i_abort) begin
      state_d   = IDLE;
      vld_sr_d  = '0;
      last_sr_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      vld_sr_d[0]  = issue;
      last_sr_d[0] = issue && (idx_q == last_idx_q);
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr_d[i]  = vld_sr_q[i-1];
        last_sr_d[i] = last_sr_q[i-1];
      end

      if (push) begin
        fifo_dat_d[wr_ptr_q]  = wr_dat;
        fifo_last_d[wr_ptr_q] = last_sr_q[RD_LATENCY-1];
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d     = RUN;
            idx_d       = '0;
            last_idx_d  = i_last_idx;
            next_addr_d = i_base_addr;
            done_d      = 1'b0;
          end
        end
        RUN: begin
          if (issue) begin
            mem_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_WIDTH'(NUM_BYTE);
            // Equality test before increment keeps a full-range last_idx from wrapping.
            if (idx_q == last_idx_q) begin
              state_d = DRAIN;
            end else begin
              idx_d = idx_q + CNT_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if ((count_q == '0) && (vld_sr_q == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_idx_q  <= '0;
      next_addr_q <= '0;
      mem_addr_q  <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      next_addr_q <= next_addr_d;
      mem_addr_q  <= mem_addr_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_last_q <= fifo_last_d;
      done_q      <= done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dat_q[i] <= fifo_dat_d[i];
      end
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign mem_enb  = issue;
  assign mem_addr = issue ? next_addr_q : mem_addr_q;
  assign mem_idat = '0;
  assign mem_wren = '0;
  assign mem_rst  = 1'b0;
  assign o_tvalid = (count_q != '0);
  assign o_tdata  = fifo_dat_q[rd_ptr_q];
  assign o_tlast  = o_tvalid && fifo_last_q[rd_ptr_q];

endmodule
